// File: rtl/arbiter_credit_rr_if.sv
// Link-side bundle of the credit-based output-port allocator.
// The requester/crossbar side drives master; the allocator takes slave.
interface arbiter_credit_rr_if #(
    parameter int CREDIT_W = 3
);
    logic [4:0]          Req;
    logic [4:0]          Tail;
    logic                Credit_in;
    logic [4:0]          Grant;
    logic [4:0]          Xbar_sel;
    logic                Valid_out;
    logic [CREDIT_W-1:0] Credit_cnt;
    logic                Busy;
    logic                Credit_err;

    modport master (
        output Req, Tail, Credit_in,
        input  Grant, Xbar_sel, Valid_out, Credit_cnt, Busy, Credit_err
    );

    modport slave (
        input  Req, Tail, Credit_in,
        output Grant, Xbar_sel, Valid_out, Credit_cnt, Busy, Credit_err
    );
endinterface

// File: rtl/arbiter_credit_rr.sv
// Round-robin output-port allocator with wormhole locking and a downstream
// credit counter. Requester order: bit0=N, 1=E, 2=W, 3=S, 4=L.
module arbiter_credit_rr #(
    parameter int CREDITS  = 4,
    parameter int CREDIT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    arbiter_credit_rr_if.slave bus
);
    // state     | meaning
    // ST_IDLE   | no owner; arbitrate among requesters, no flit moves
    // ST_LOCKED | r_owner holds the port until its tail flit transfers
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    localparam logic [CREDIT_W-1:0] CNT_MAX = CREDIT_W'(CREDITS);

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_owner, w_owner_nxt;
    logic [2:0]          r_rr_ptr, w_rr_ptr_nxt;
    logic [CREDIT_W-1:0] r_cnt, w_cnt_nxt;
    logic                r_err, w_err_nxt;
    logic                w_found;
    logic [2:0]          w_pick;
    logic [4:0]          w_owner_oh;
    logic                w_grant_ok;

    function automatic logic [2:0] mod5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    // Scan from the farthest slot back so the slot nearest r_rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (bus.Req[mod5({1'b0, r_rr_ptr} + 4'(k))]) begin
                w_found = 1'b1;
                w_pick  = mod5({1'b0, r_rr_ptr} + 4'(k));
            end
        end
    end

    assign w_owner_oh = 5'b00001 << r_owner;
    assign w_grant_ok = (r_state == ST_LOCKED) && bus.Req[r_owner] && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= 3'd0;
            r_rr_ptr <= 3'd0;
            r_cnt    <= CNT_MAX;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_pick;
                end
            end
            ST_LOCKED: begin
                if (w_grant_ok && bus.Tail[r_owner]) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A credit returned alongside a send cancels out; a return into a full counter is an error.
        if (w_grant_ok && !bus.Credit_in) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end else if (!w_grant_ok && bus.Credit_in) begin
            if (r_cnt < CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
            else                 w_err_nxt = 1'b1;
        end
    end

    always_comb begin
        bus.Grant      = w_grant_ok ? w_owner_oh : 5'b00000;
        bus.Xbar_sel   = (r_state == ST_LOCKED) ? w_owner_oh : 5'b00000;
        bus.Valid_out  = w_grant_ok;
        bus.Busy       = (r_state == ST_LOCKED);
        bus.Credit_cnt = r_cnt;
        bus.Credit_err = r_err;
    end
endmodule

// File: tb/tb_arbiter_credit_rr.sv
// Directed bench for arbiter_credit_rr: arbitration order, wormhole locking,
// credit stall/return, sticky credit error and mid-packet reset.
module tb_arbiter_credit_rr;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    arbiter_credit_rr_if #(.CREDIT_W(3)) bus ();

    arbiter_credit_rr #(.CREDITS(4), .CREDIT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] oh(input int k);
        return 5'b00001 << k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] req, input logic [4:0] tail, input logic cin);
        bus.Req       = req;
        bus.Tail      = tail;
        bus.Credit_in = cin;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] g, input logic [4:0] x,
                              input logic b, input logic [2:0] c);
        check({tag, ".grant"}, 32'(bus.Grant), 32'(g));
        check({tag, ".valid"}, 32'(bus.Valid_out), 32'(|g));
        check({tag, ".xbar"},  32'(bus.Xbar_sel), 32'(x));
        check({tag, ".busy"},  32'(bus.Busy), 32'(b));
        check({tag, ".cnt"},   32'(bus.Credit_cnt), 32'(c));
    endtask

    initial begin
        rst = 1'b1;
        drive(5'b00000, 5'b00000, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        expect_out("reset", 5'b00000, 5'b00000, 1'b0, 3'd4);
        check("reset.err", 32'(bus.Credit_err), 32'd0);

        // Fairness: all requesting single-flit packets, winners N,E,W,S,L,N.
        for (int w = 0; w < 6; w++) begin
            drive(5'b11111, 5'b11111, w != 0);
            expect_out($sformatf("fair%0d.arb", w), 5'b00000, 5'b00000, 1'b0, (w == 0) ? 3'd4 : 3'd3);
            cyc();
            drive(5'b11111, 5'b11111, 1'b0);
            expect_out($sformatf("fair%0d.win", w), oh(w % 5), oh(w % 5), 1'b1, 3'd4);
            cyc();
        end
        drive(5'b00000, 5'b00000, 1'b1);
        cyc();

        // Pointer: E completes, then N+L request -> L wins.
        drive(5'b00010, 5'b00010, 1'b0);
        expect_out("ptr.e_arb", 5'b00000, 5'b00000, 1'b0, 3'd4);
        cyc();
        expect_out("ptr.e_win", 5'b00010, 5'b00010, 1'b1, 3'd4);
        cyc();
        drive(5'b10001, 5'b10001, 1'b0);
        expect_out("ptr.arb", 5'b00000, 5'b00000, 1'b0, 3'd3);
        cyc();
        expect_out("ptr.win", 5'b10000, 5'b10000, 1'b1, 3'd3);
        cyc();

        // Same-cycle credit return and grant at count 2 holds the count.
        drive(5'b00001, 5'b00000, 1'b0);
        expect_out("same.arb", 5'b00000, 5'b00000, 1'b0, 3'd2);
        cyc();
        drive(5'b00001, 5'b00000, 1'b1);
        expect_out("same.grant", 5'b00001, 5'b00001, 1'b1, 3'd2);
        cyc();
        drive(5'b00001, 5'b00001, 1'b0);
        expect_out("same.hold", 5'b00001, 5'b00001, 1'b1, 3'd2);
        cyc();

        // Refill to 4, then one extra return -> sticky error.
        drive(5'b00000, 5'b00000, 1'b1);
        repeat (4) cyc();
        drive(5'b00000, 5'b00000, 1'b0);
        check("ovf.cnt", 32'(bus.Credit_cnt), 32'd4);
        check("ovf.err", 32'(bus.Credit_err), 32'd1);

        // Three-flit packet from N.
        drive(5'b00001, 5'b00000, 1'b0);
        expect_out("n3.c0", 5'b00000, 5'b00000, 1'b0, 3'd4);
        cyc();
        expect_out("n3.f1", 5'b00001, 5'b00001, 1'b1, 3'd4);
        cyc();
        expect_out("n3.f2", 5'b00001, 5'b00001, 1'b1, 3'd3);
        cyc();
        drive(5'b00001, 5'b00001, 1'b0);
        expect_out("n3.f3", 5'b00001, 5'b00001, 1'b1, 3'd2);
        cyc();
        drive(5'b00000, 5'b00000, 1'b0);
        expect_out("n3.c4", 5'b00000, 5'b00000, 1'b0, 3'd1);
        check("n3.err_sticky", 32'(bus.Credit_err), 32'd1);
        drive(5'b00000, 5'b00000, 1'b1);
        repeat (3) cyc();
        drive(5'b00000, 5'b00000, 1'b0);

        // Credit stall: 6-flit packet from S with 4 credits.
        drive(5'b01000, 5'b00000, 1'b0);
        expect_out("st.arb", 5'b00000, 5'b00000, 1'b0, 3'd4);
        cyc();
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("st.g%0d", i), 5'b01000, 5'b01000, 1'b1, 3'(4 - i));
            cyc();
        end
        expect_out("st.stall", 5'b00000, 5'b01000, 1'b1, 3'd0);
        drive(5'b01000, 5'b00000, 1'b1);
        expect_out("st.cin_same", 5'b00000, 5'b01000, 1'b1, 3'd0);
        cyc();
        drive(5'b01000, 5'b00000, 1'b0);
        expect_out("st.one", 5'b01000, 5'b01000, 1'b1, 3'd1);
        cyc();
        expect_out("st.stall2", 5'b00000, 5'b01000, 1'b1, 3'd0);
        drive(5'b01000, 5'b00000, 1'b1);
        cyc();
        drive(5'b01000, 5'b01000, 1'b0);
        expect_out("st.tail", 5'b01000, 5'b01000, 1'b1, 3'd1);
        cyc();
        drive(5'b00000, 5'b00000, 1'b0);
        expect_out("st.idle", 5'b00000, 5'b00000, 1'b0, 3'd0);
        drive(5'b00000, 5'b00000, 1'b1);
        repeat (4) cyc();
        drive(5'b00000, 5'b00000, 1'b0);
        check("st.refill", 32'(bus.Credit_cnt), 32'd4);

        // Reset in the middle of a W packet.
        drive(5'b00100, 5'b00000, 1'b0);
        cyc();
        repeat (3) cyc();
        expect_out("w.mid", 5'b00100, 5'b00100, 1'b1, 3'd1);
        rst = 1'b1;
        cyc();
        expect_out("rst.mid", 5'b00000, 5'b00000, 1'b0, 3'd4);
        check("rst.err", 32'(bus.Credit_err), 32'd0);
        rst = 1'b0;
        drive(5'b10001, 5'b00000, 1'b0);
        expect_out("rst.arb", 5'b00000, 5'b00000, 1'b0, 3'd4);
        cyc();
        expect_out("rst.win", 5'b00001, 5'b00001, 1'b1, 3'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
